load_hazard_scoreboard: RTL and testbench

Parametrised load-use hazard controller for the 5-stage MIPS pipeline, replacing the single-slot ID/EX load check. It keeps a shift-register scoreboard of in-flight loads whose data is not yet forwardable, so load latency is configurable. It also handles data-memory wait freezes and ID-stage flushes, and counts hazard bubbles for performance analysis. It sits beside the ID stage and drives the PC, IF/ID and ID/EX write and clear controls.

---
 rtl/load_hazard_scoreboard.sv | 126 ++++++++++++
 tb/tb_load_hazard_scoreboard.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/load_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// load_hazard_scoreboard
//
// Load-use hazard controller for the 5-stage MIPS pipeline. It tracks loads
// that are in flight and whose data cannot be forwarded yet, using a shift
// register of LOAD_LATENCY slots (slot 0 is the instruction now in EX). From
// that scoreboard and the ID-stage operand fields it drives the PC, IF/ID and
// ID/EX write/clear controls. It also applies data-memory freezes and ID
// flushes, and it keeps a saturating count of hazard bubbles.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   id_rs, id_rt             source register fields of the ID instruction
//   id_jmp                   ID is a jump (rs is not a source)
//   id_dst, id_beq, id_bne,
//   id_memwrite              any set -> rt is a source
//   id_memread, id_load_dst  ID instruction is a load, and its destination
//   mem_busy                 data memory stall; freezes the whole pipeline
//   flush_id                 squash the instruction in ID
//   pc_write, ifid_write,
//   idex_write               pipeline register load enables
//   ctrl_bubble              zero the control fields entering ID/EX
//   ifid_flush               clear IF/ID
//   stall_cnt                saturating count of hazard bubble cycles
// ---------------------------------------------------------------------------
module load_hazard_scoreboard #(
    parameter int REG_ADDR_W   = 5,
    parameter int LOAD_LATENCY = 1,   // must be >= 1
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_jmp,
    input  logic                  id_dst,
    input  logic                  id_beq,
    input  logic                  id_bne,
    input  logic                  id_memwrite,
    input  logic                  id_memread,
    input  logic [REG_ADDR_W-1:0] id_load_dst,
    input  logic                  mem_busy,
    input  logic                  flush_id,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  idex_write,
    output logic                  ctrl_bubble,
    output logic                  ifid_flush,
    output logic [CNT_W-1:0]      stall_cnt
);

    logic [LOAD_LATENCY-1:0]                 valid_q, valid_d;
    logic [LOAD_LATENCY-1:0][REG_ADDR_W-1:0] dst_q, dst_d;
    logic [CNT_W-1:0]                        stall_cnt_q;
    logic [LOAD_LATENCY-1:0]                 hit;
    logic                                    uses_rs, uses_rt, hazard;

    assign uses_rs = ~id_jmp;
    assign uses_rt = id_dst | id_beq | id_bne | id_memwrite;

    // A slot only matters while its value is not yet forwardable. A load to
    // $0 never creates a dependency.
    genvar gi;
    generate
        for (gi = 0; gi < LOAD_LATENCY; gi++) begin : g_hit
            assign hit[gi] = valid_q[gi] && (dst_q[gi] != '0) &&
                             (((dst_q[gi] == id_rs) && uses_rs) ||
                              ((dst_q[gi] == id_rt) && uses_rt));
        end
    endgenerate

    assign hazard = |hit;

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        ctrl_bubble = 1'b0;
        ifid_flush  = 1'b0;
        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            ctrl_bubble = 1'b1;
        end else if (mem_busy) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
        end else if (flush_id) begin
            // The ID instruction is dead, so any hazard it has is irrelevant.
            ctrl_bubble = 1'b1;
            ifid_flush  = 1'b1;
        end else if (hazard) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ctrl_bubble = 1'b1;
        end
    end

    // Shift the scoreboard one slot per advancing cycle. A bubbled or flushed
    // load never reaches EX, so it must not occupy a slot.
    assign valid_d[0] = id_memread & ~ctrl_bubble;
    assign dst_d[0]   = id_load_dst;
    generate
        for (gi = 1; gi < LOAD_LATENCY; gi++) begin : g_shift
            assign valid_d[gi] = valid_q[gi-1];
            assign dst_d[gi]   = dst_q[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= '0;
            dst_q       <= '0;
            stall_cnt_q <= '0;
        end else if (!mem_busy) begin
            valid_q <= valid_d;
            dst_q   <= dst_d;
            if (hazard && !flush_id && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_load_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_load_hazard_scoreboard
//
// Three instances share one input stimulus:
//   u_l1  : LOAD_LATENCY=1, CNT_W=16
//   u_l2  : LOAD_LATENCY=2, CNT_W=16
//   u_sat : LOAD_LATENCY=1, CNT_W=2
// Control outputs are packed as {pc_write, ifid_write, idex_write,
// ctrl_bubble, ifid_flush}.
// ---------------------------------------------------------------------------
module tb_load_hazard_scoreboard;

    localparam logic [4:0] C_NORM  = 5'b11100;
    localparam logic [4:0] C_HAZ   = 5'b00110;
    localparam logic [4:0] C_BUSY  = 5'b00000;
    localparam logic [4:0] C_FLUSH = 5'b11111;
    localparam logic [4:0] C_RST   = 5'b00010;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, id_load_dst = '0;
    logic       id_jmp = 1'b0, id_dst = 1'b0, id_beq = 1'b0, id_bne = 1'b0;
    logic       id_memwrite = 1'b0, id_memread = 1'b0;
    logic       mem_busy = 1'b0, flush_id = 1'b0;

    logic        a_pc, a_ifw, a_idw, a_bub, a_fl;
    logic        b_pc, b_ifw, b_idw, b_bub, b_fl;
    logic        c_pc, c_ifw, c_idw, c_bub, c_fl;
    logic [15:0] cnt_a, cnt_b;
    logic [1:0]  cnt_c;
    logic [4:0]  ctl_a, ctl_b, ctl_c;

    assign ctl_a = {a_pc, a_ifw, a_idw, a_bub, a_fl};
    assign ctl_b = {b_pc, b_ifw, b_idw, b_bub, b_fl};
    assign ctl_c = {c_pc, c_ifw, c_idw, c_bub, c_fl};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    load_hazard_scoreboard #(.REG_ADDR_W(5), .LOAD_LATENCY(1), .CNT_W(16)) u_l1 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_jmp(id_jmp),
        .id_dst(id_dst), .id_beq(id_beq), .id_bne(id_bne), .id_memwrite(id_memwrite),
        .id_memread(id_memread), .id_load_dst(id_load_dst), .mem_busy(mem_busy),
        .flush_id(flush_id), .pc_write(a_pc), .ifid_write(a_ifw), .idex_write(a_idw),
        .ctrl_bubble(a_bub), .ifid_flush(a_fl), .stall_cnt(cnt_a));

    load_hazard_scoreboard #(.REG_ADDR_W(5), .LOAD_LATENCY(2), .CNT_W(16)) u_l2 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_jmp(id_jmp),
        .id_dst(id_dst), .id_beq(id_beq), .id_bne(id_bne), .id_memwrite(id_memwrite),
        .id_memread(id_memread), .id_load_dst(id_load_dst), .mem_busy(mem_busy),
        .flush_id(flush_id), .pc_write(b_pc), .ifid_write(b_ifw), .idex_write(b_idw),
        .ctrl_bubble(b_bub), .ifid_flush(b_fl), .stall_cnt(cnt_b));

    load_hazard_scoreboard #(.REG_ADDR_W(5), .LOAD_LATENCY(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_jmp(id_jmp),
        .id_dst(id_dst), .id_beq(id_beq), .id_bne(id_bne), .id_memwrite(id_memwrite),
        .id_memread(id_memread), .id_load_dst(id_load_dst), .mem_busy(mem_busy),
        .flush_id(flush_id), .pc_write(c_pc), .ifid_write(c_ifw), .idex_write(c_idw),
        .ctrl_bubble(c_bub), .ifid_flush(c_fl), .stall_cnt(cnt_c));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-16s observed %0h expected %0h", tag, obs, exp);
    endtask

    // Present one ID instruction at the falling edge; outputs are checked 1ns later.
    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic jmp,
                         input logic dst, input logic beq, input logic memread,
                         input logic [4:0] ldst, input logic busy, input logic flush);
        @(negedge clk);
        id_rs = rs; id_rt = rt; id_jmp = jmp; id_dst = dst; id_beq = beq;
        id_bne = 1'b0; id_memwrite = 1'b0; id_memread = memread;
        id_load_dst = ldst; mem_busy = busy; flush_id = flush;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        id_rs = '0; id_rt = '0; id_jmp = 1'b0; id_dst = 1'b0; id_beq = 1'b0;
        id_bne = 1'b0; id_memwrite = 1'b0; id_memread = 1'b0; id_load_dst = '0;
        mem_busy = 1'b0; flush_id = 1'b0;
        #1;
        check("rst_ctl", 32'(ctl_b), 32'(C_RST));
        check("rst_cnt", 32'(cnt_b), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // LOAD_LATENCY=1: lw $5 then consumer rs=5
        do_reset();
        drive(5'd0, 5'd0, 0, 0, 0, 1, 5'd5, 0, 0);
        check("l1_lw", 32'(ctl_a), 32'(C_NORM));
        drive(5'd5, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0);
        check("l1_stall", 32'(ctl_a), 32'(C_HAZ));
        check("l2_stall1", 32'(ctl_b), 32'(C_HAZ));
        drive(5'd5, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0);
        check("l1_release", 32'(ctl_a), 32'(C_NORM));
        check("l2_stall2", 32'(ctl_b), 32'(C_HAZ));
        drive(5'd5, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0);
        check("l2_release", 32'(ctl_b), 32'(C_NORM));
        check("l1_cnt", 32'(cnt_a), 32'd1);
        check("l2_cnt", 32'(cnt_b), 32'd2);

        // LOAD_LATENCY=2: lw $7 then consumer rt=7 with id_dst
        do_reset();
        drive(5'd0, 5'd0, 0, 0, 0, 1, 5'd7, 0, 0);
        drive(5'd2, 5'd7, 0, 1, 0, 0, 5'd0, 0, 0);
        check("rt_stall1", 32'(ctl_b), 32'(C_HAZ));
        drive(5'd2, 5'd7, 0, 1, 0, 0, 5'd0, 0, 0);
        check("rt_stall2", 32'(ctl_b), 32'(C_HAZ));
        drive(5'd2, 5'd7, 0, 1, 0, 0, 5'd0, 0, 0);
        check("rt_release", 32'(ctl_b), 32'(C_NORM));
        check("rt_cnt", 32'(cnt_b), 32'd2);

        // One independent instruction between load and consumer
        do_reset();
        drive(5'd0, 5'd0, 0, 0, 0, 1, 5'd7, 0, 0);
        drive(5'd3, 5'd3, 0, 1, 0, 0, 5'd0, 0, 0);
        check("gap_indep", 32'(ctl_b), 32'(C_NORM));
        drive(5'd2, 5'd7, 0, 1, 0, 0, 5'd0, 0, 0);
        check("gap_stall", 32'(ctl_b), 32'(C_HAZ));
        drive(5'd2, 5'd7, 0, 1, 0, 0, 5'd0, 0, 0);
        check("gap_release", 32'(ctl_b), 32'(C_NORM));
        check("gap_cnt", 32'(cnt_b), 32'd1);

        // Load to $0 never stalls
        do_reset();
        drive(5'd0, 5'd0, 0, 0, 0, 1, 5'd0, 0, 0);
        drive(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0);
        check("r0_l1", 32'(ctl_a), 32'(C_NORM));
        check("r0_l2", 32'(ctl_b), 32'(C_NORM));

        // Jump does not read rs; beq reads rt
        do_reset();
        drive(5'd0, 5'd0, 0, 0, 0, 1, 5'd4, 0, 0);
        drive(5'd4, 5'd0, 1, 0, 0, 0, 5'd0, 0, 0);
        check("jmp_l1", 32'(ctl_a), 32'(C_NORM));
        check("jmp_l2", 32'(ctl_b), 32'(C_NORM));
        drive(5'd0, 5'd4, 0, 0, 1, 0, 5'd0, 0, 0);
        check("beq_l2", 32'(ctl_b), 32'(C_HAZ));
        check("beq_l1", 32'(ctl_a), 32'(C_NORM));

        // mem_busy freezes a pending hazard without consuming its cycles
        do_reset();
        drive(5'd0, 5'd0, 0, 0, 0, 1, 5'd7, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(5'd7, 5'd0, 0, 0, 0, 0, 5'd0, 1, 0);
            check("busy_ctl", 32'(ctl_b), 32'(C_BUSY));
            check("busy_cnt", 32'(cnt_b), 32'd0);
        end
        drive(5'd7, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0);
        check("busy_resume1", 32'(ctl_b), 32'(C_HAZ));
        drive(5'd7, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0);
        check("busy_resume2", 32'(ctl_b), 32'(C_HAZ));
        drive(5'd7, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0);
        check("busy_release", 32'(ctl_b), 32'(C_NORM));
        check("busy_cnt_end", 32'(cnt_b), 32'd2);

        // Flush in the hazard cycle: flush wins and the squashed load leaves no slot
        do_reset();
        drive(5'd0, 5'd0, 0, 0, 0, 1, 5'd7, 0, 0);
        drive(5'd7, 5'd0, 0, 0, 0, 1, 5'd9, 0, 1);
        check("flush_l2", 32'(ctl_b), 32'(C_FLUSH));
        check("flush_l1", 32'(ctl_a), 32'(C_FLUSH));
        drive(5'd9, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0);
        check("flush_slot0_l2", 32'(ctl_b), 32'(C_NORM));
        check("flush_slot0_l1", 32'(ctl_a), 32'(C_NORM));
        check("flush_cnt", 32'(cnt_b), 32'd0);

        // CNT_W=2 counter saturates at 3
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            drive(5'd0, 5'd0, 0, 0, 0, 1, 5'd5, 0, 0);
            drive(5'd5, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0);
            check("sat_stall", 32'(ctl_c), 32'(C_HAZ));
            drive(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0);
            check("sat_cnt", 32'(cnt_c), (k > 3) ? 32'd3 : 32'(k));
        end

        // Asynchronous reset in the middle of a stall
        drive(5'd0, 5'd0, 0, 0, 0, 1, 5'd5, 0, 0);
        drive(5'd5, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0);
        check("mid_stall", 32'(ctl_c), 32'(C_HAZ));
        rst = 1'b1;
        #1;
        check("async_cnt", 32'(cnt_c), 32'd0);
        check("async_ctl", 32'(ctl_c), 32'(C_RST));
        rst = 1'b0;
        #1;
        check("post_rst_ctl", 32'(ctl_c), 32'(C_NORM));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
